// File: rtl/mul_signed_approx_pipe.sv
// Pipelined signed array multiplier with per-transaction column truncation.
// Rank 0 captures the operands; reduction is split over ranks 1 and 2, later ranks only delay.
module mul_signed_approx_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4,
  parameter int KW     = $clog2(2*WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [KW-1:0]        in_k,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int PW      = 2*WIDTH;
  localparam int LO_ROWS = (STAGES == 1) ? WIDTH : WIDTH/2;

  // Sum of partial-product bits for multiplier rows [lo,hi), columns >= k.
  // Bits with exactly one sign operand carry negative weight (Baugh-Wooley form).
  function automatic logic [PW-1:0] pp_sum(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic [KW-1:0]    k,
                                           input int               lo,
                                           input int               hi);
    logic [PW-1:0] acc;
    logic [PW-1:0] bitw;
    acc = '0;
    for (int j = 0; j < WIDTH; j++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (j >= lo && j < hi && a[i] && b[j] && (i + j) >= int'(k)) begin
          bitw = PW'(1) << (i + j);
          if ((i == WIDTH-1) != (j == WIDTH-1)) acc = acc - bitw;
          else                                  acc = acc + bitw;
        end
      end
    end
    return acc;
  endfunction

  logic [STAGES:0]   vld_pipe;
  logic              w_adv;
  logic [WIDTH-1:0]  r_a0, r_b0;
  logic [KW-1:0]     r_k0;
  logic [TAG_W-1:0]  r_tag  [STAGES:0];
  logic [PW-1:0]     r_prod [STAGES:1];
  logic [PW-1:0]     w_lo, w_hi;

  // Simple global stall: any held output freezes every rank, bubbles included.
  assign w_adv = out_ready | ~vld_pipe[STAGES];
  assign w_lo  = pp_sum(r_a0, r_b0, r_k0, 0, LO_ROWS);

  generate
    if (STAGES > 1) begin : g_split
      logic [WIDTH-1:0] r_a1, r_b1;
      logic [KW-1:0]    r_k1;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a1 <= '0;
          r_b1 <= '0;
          r_k1 <= '0;
        end else if (w_adv) begin
          r_a1 <= r_a0;
          r_b1 <= r_b0;
          r_k1 <= r_k0;
        end
      end
      assign w_hi = pp_sum(r_a1, r_b1, r_k1, LO_ROWS, WIDTH);
    end else begin : g_whole
      assign w_hi = '0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      r_a0     <= '0;
      r_b0     <= '0;
      r_k0     <= '0;
      for (int s = 0; s <= STAGES; s++) r_tag[s] <= '0;
      for (int s = 1; s <= STAGES; s++) r_prod[s] <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else if (w_adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
      r_a0     <= in_a;
      r_b0     <= in_b;
      r_k0     <= in_k;
      r_tag[0] <= in_tag;
      for (int s = 1; s <= STAGES; s++) r_tag[s] <= r_tag[s-1];
      r_prod[1] <= w_lo;
      for (int s = 2; s <= STAGES; s++)
        r_prod[s] <= (s == 2) ? r_prod[1] + w_hi : r_prod[s-1];
    end
  end

  assign in_ready  = w_adv;
  assign out_valid = vld_pipe[STAGES];
  assign out_p     = r_prod[STAGES];
  assign out_tag   = r_tag[STAGES];

endmodule

// File: tb/tb_mul_signed_approx_pipe.sv
// Randomised and directed bench for mul_signed_approx_pipe against a scoreboard model.
module tb_mul_signed_approx_pipe;
  localparam int W = 8;
  localparam int S = 2;

  logic clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]   in_a, in_b;
  logic [3:0]     in_k, in_tag, out_tag;
  logic [2*W-1:0] out_p;

  mul_signed_approx_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_k(in_k), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_p(out_p), .out_tag(out_tag));

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] p;
    logic [3:0]  t;
    int          c;
    int          s;
  } ent_t;

  ent_t        exp_q[$];
  logic [19:0] got_q[$];
  int          total = 0, bad = 0;
  int          cycn = 0, stalls = 0, pc = 0;
  bit          pat_on = 0, prev_stall = 0, prev_flush = 0;
  logic [15:0] last_p;
  logic [3:0]  last_t;
  bit          pat[5] = '{1, 0, 0, 0, 1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact signed product at k=0, otherwise the weighted bit sum over kept columns.
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] k);
    int     sa, sb, pr;
    longint acc;
    logic [15:0] r;
    if (k == 0) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      pr = sa * sb;
      r  = pr[15:0];
      return r;
    end
    acc = 0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (a[i] && b[j] && (i + j) >= int'(k)) begin
          if ((i == W-1) ^ (j == W-1)) acc = acc - (longint'(1) << (i + j));
          else                         acc = acc + (longint'(1) << (i + j));
        end
    r = acc[15:0];
    return r;
  endfunction

  function automatic logic [19:0] got_at(input int i);
    return (got_q.size() > i) ? got_q[i] : 20'hFFFFF;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 0;
      prev_flush = 0;
    end else begin
      ent_t e;
      cycn++;
      chk("in_ready", {31'd0, in_ready}, {31'd0, out_ready | ~out_valid});
      if (prev_stall && !prev_flush) begin
        chk("hold_v", {31'd0, out_valid}, 32'd1);
        chk("hold_p", {16'd0, out_p}, {16'd0, last_p});
        chk("hold_t", {28'd0, out_tag}, {28'd0, last_t});
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("spurious_out", {31'd0, out_valid}, 32'd0);
          else begin
            e = exp_q.pop_front();
            chk("out_p", {16'd0, out_p}, {16'd0, e.p});
            chk("out_tag", {28'd0, out_tag}, {28'd0, e.t});
            chk("latency", cycn - e.c, S + 1 + stalls - e.s);
            got_q.push_back({out_p, out_tag});
          end
        end
        if (in_valid && in_ready) begin
          e.p = model(in_a, in_b, in_k);
          e.t = in_tag;
          e.c = cycn;
          e.s = stalls;
          exp_q.push_back(e);
        end
      end
      if (!in_ready) stalls++;
      prev_stall = out_valid & ~out_ready;
      prev_flush = flush;
      last_p = out_p;
      last_t = out_tag;
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] k, input logic [3:0] t);
    int   n = 0;
    logic acc;
    in_valid = 1; in_a = a; in_b = b; in_k = k; in_tag = t;
    forever begin
      if (pat_on) begin out_ready = pat[pc % 5]; pc++; end
      #3 acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
      if (++n > 100) begin chk("send_timeout", {31'd0, acc}, 32'd1); break; end
    end
    in_valid = 0;
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) begin
      if (pat_on) begin out_ready = pat[pc % 5]; pc++; end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    clk = 0; rst_n = 0; flush = 0; in_valid = 0; out_ready = 1;
    in_a = 0; in_b = 0; in_k = 0; in_tag = 0;
    #3;
    chk("rst_ov", {31'd0, out_valid}, 32'd0);
    chk("rst_p", {16'd0, out_p}, 32'd0);
    chk("rst_tag", {28'd0, out_tag}, 32'd0);
    chk("rst_rdy", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 rst_n = 1;

    // exact products, back to back
    got_q.delete();
    send(8'h80, 8'h80, 0, 1);
    send(8'hFF, 8'h01, 0, 2);
    send(8'h7F, 8'h80, 0, 3);
    idle(6);
    chk("t1_cnt", got_q.size(), 3);
    chk("t1_0", got_at(0), {16'h4000, 4'd1});
    chk("t1_1", got_at(1), {16'hFFFF, 4'd2});
    chk("t1_2", got_at(2), {16'hC080, 4'd3});

    // truncation and mixed-k stream
    got_q.delete();
    send(8'd3, 8'd3, 2, 4);
    send(8'd3, 8'd3, 0, 5);
    for (int i = 0; i < 8; i++)
      send(8'($urandom), 8'($urandom), 4'($urandom_range(15)), 4'(i));
    idle(6);
    chk("t2_k2", got_at(0), {16'h0004, 4'd4});
    chk("t2_k0", got_at(1), {16'h0009, 4'd5});
    chk("t2_cnt", got_q.size(), 10);

    // streaming with out_ready pattern 1,0,0,0,1
    got_q.delete();
    pat_on = 1; pc = 0;
    for (int i = 0; i < 20; i++)
      send(8'($urandom), 8'($urandom), 4'($urandom_range(15)), 4'(i));
    idle(40);
    pat_on = 0; out_ready = 1;
    idle(4);
    chk("t3_cnt", got_q.size(), 20);

    // flush with two results held and a same-edge input
    got_q.delete();
    out_ready = 0;
    send(8'd11, 8'd12, 0, 6);
    send(8'd13, 8'd14, 0, 7);
    idle(2);
    chk("t4_full", {31'd0, out_valid}, 32'd1);
    flush = 1; in_valid = 1; in_a = 8'd9; in_b = 8'd9; in_k = 0; in_tag = 4'd9;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    chk("t4_ov", {31'd0, out_valid}, 32'd0);
    out_ready = 1;
    idle(8);
    chk("t4_none", got_q.size(), 0);

    // asynchronous reset mid-stream
    send(8'($urandom), 8'($urandom), 0, 10);
    send(8'($urandom), 8'($urandom), 0, 11);
    send(8'($urandom), 8'($urandom), 0, 12);
    #2 rst_n = 0;
    #1;
    chk("t5_ov", {31'd0, out_valid}, 32'd0);
    chk("t5_p", {16'd0, out_p}, 32'd0);
    chk("t5_tag", {28'd0, out_tag}, 32'd0);
    chk("t5_rdy", {31'd0, in_ready}, 32'd1);
    #3 rst_n = 1;
    @(posedge clk); #1;
    got_q.delete();
    send(8'd5, 8'hFD, 0, 13);
    idle(5);
    chk("t5_cnt", got_q.size(), 1);
    chk("t5_res", got_at(0), {16'hFFF1, 4'd13});

    // random sweep over all k
    for (int i = 0; i < 10000; i++)
      send(8'($urandom), 8'($urandom), 4'($urandom_range(15)), 4'($urandom));
    // exhaustive operands at k=0
    for (int x = 0; x < 65536; x++)
      send(x[15:8], x[7:0], 0, x[3:0]);
    idle(8);
    chk("drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
